spi_master: RTL and testbench

- SPI mode-0 master. Drives chip select, serial clock and MOSI, and captures MISO for one width-bit word per transaction.
- It is the initiator end of the link whose peripheral side uses our shift register. That register samples serial input on the peripheral clock rising edge and shifts it toward bit 0, so data travels LSB-first.
- Sits between the host-side control logic and the off-block SPI pins. Host gets a start/busy/done handshake and parallel tx/rx words.

---
 rtl/spi_master.sv | 172 +++++++++++++++++
 tb/tb_spi_master.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master: one WIDTH-bit LSB-first transfer per start request.
// MOSI is launched at chip-select assertion and on each sclk falling edge.
// MISO is captured on the same system edge that raises sclk.
module spi_master #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] tx_data_i,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cs_o,
  output logic             sclk_o,
  output logic             mosi_o,
  input  logic             miso_i
);

  localparam int unsigned BIT_W = $clog2(WIDTH) + 1;
  // The trail phase runs for two half-periods plus one cycle, so the
  // divider must be able to reach 2*CLK_DIV.
  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] TRAIL_LAST = DIV_W'(2 * CLK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    TRAIL = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   tx_q, tx_d;
  logic [WIDTH-1:0]   rx_q, rx_d;
  logic [WIDTH-1:0]   rx_data_q, rx_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cs_q, cs_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               phase_end_c;

  // Last divider count of the current phase.
  assign phase_end_c = (state_q == TRAIL) ? (div_q == TRAIL_LAST)
                                          : (div_q == DIV_LAST);

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_i)     state_d = LEAD;
      LEAD:  if (phase_end_c) state_d = HIGH;
      HIGH:  if (phase_end_c) state_d = (bit_cnt_q == BIT_LAST) ? TRAIL : LOW;
      LOW:   if (phase_end_c) state_d = HIGH;
      TRAIL: if (phase_end_c) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;

    if (state_q != IDLE) begin
      div_d = phase_end_c ? '0 : div_q + DIV_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        if (start_i) begin
          tx_d      = tx_data_i;
          bit_cnt_d = '0;
          div_d     = '0;
          mosi_d    = tx_data_i[0];
          cs_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      LEAD, LOW: begin
        if (phase_end_c) begin
          sclk_d = 1'b1;
          rx_d   = {miso_i, rx_q[WIDTH-1:1]};
        end
      end
      HIGH: begin
        if (phase_end_c) begin
          sclk_d = 1'b0;
          if (bit_cnt_q != BIT_LAST) begin
            tx_d      = {tx_q[0], tx_q[WIDTH-1:1]};
            mosi_d    = tx_q[1];
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      TRAIL: begin
        if (phase_end_c) begin
          cs_d      = 1'b1;
          done_d    = 1'b1;
          rx_data_d = rx_q;
        end
      end
      default: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q     <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
    end
  end

  assign rx_data_o = rx_data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign cs_o      = cs_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: loopback, peripheral shift register,
// ignored starts, back-to-back, mid-transfer reset and a CLK_DIV=1 instance.
module tb_spi_master;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned CLK_DIV = 4;
  localparam int          LAT4    = (2 * WIDTH + 2) * CLK_DIV + 1;
  localparam int          LAT1    = (2 * WIDTH + 2) * 1 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, busy, done, cs, sclk, mosi, miso;
  logic [WIDTH-1:0] tx_data, rx_data;
  logic             sel_periph, periph_load;
  logic [WIDTH-1:0] periph_q;

  logic             start1, busy1, done1, cs1, sclk1, mosi1;
  logic [WIDTH-1:0] tx1, rx1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [WIDTH-1:0] rx;
    int               lat;
  } exp_t;

  exp_t exp_q[$];
  logic exp_bits[$];

  spi_master #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) u_dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .tx_data_i(tx_data),
    .rx_data_o(rx_data), .busy_o(busy), .done_o(done), .cs_o(cs),
    .sclk_o(sclk), .mosi_o(mosi), .miso_i(miso)
  );

  spi_master #(.WIDTH(WIDTH), .CLK_DIV(1)) u_dut1 (
    .clk_i(clk), .reset_i(rst), .start_i(start1), .tx_data_i(tx1),
    .rx_data_o(rx1), .busy_o(busy1), .done_o(done1), .cs_o(cs1),
    .sclk_o(sclk1), .mosi_o(mosi1), .miso_i(mosi1)
  );

  // Peripheral: shifts toward bit 0 on sclk rising, serial out from bit 0.
  assign miso = sel_periph ? periph_q[0] : mosi;
  always @(posedge sclk or posedge periph_load) begin
    if (periph_load) periph_q <= 8'h3C;
    else             periph_q <= {mosi, periph_q[WIDTH-1:1]};
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic push_txn(input logic [WIDTH-1:0] tx, input logic [WIDTH-1:0] rx, input int nbits);
    exp_t e;
    for (int i = 0; i < nbits; i++) exp_bits.push_back(tx[i]);
    if (nbits == WIDTH) begin
      e.rx  = rx;
      e.lat = LAT4;
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [WIDTH-1:0] tx);
    tx_data = tx;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("done_timeout");
  endtask

  // Monitor for the CLK_DIV=4 instance: pops expectations on sclk rise and done.
  initial begin
    logic prev_cs, prev_sclk, prev_done;
    int   accept_cyc, rises;
    exp_t e;
    prev_cs = 1'b1; prev_sclk = 1'b0; prev_done = 1'b0;
    accept_cyc = 0; rises = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (prev_cs === 1'b1 && cs === 1'b0) begin
          accept_cyc = cyc;
          rises = 0;
        end
        if (prev_sclk === 1'b0 && sclk === 1'b1) begin
          rises++;
          check("cs_low_at_sclk_rise", 32'(cs), 32'(0));
          if (exp_bits.size() == 0) fail_now("unexpected_sclk_rise");
          else check("mosi_bit", 32'(mosi), 32'(exp_bits.pop_front()));
        end
        if (prev_done === 1'b1) check("done_one_cycle", 32'(done), 32'(0));
        if (done === 1'b1) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            e = exp_q.pop_front();
            check("rx_data", 32'(rx_data), 32'(e.rx));
            check("done_latency", 32'(cyc - accept_cyc), 32'(e.lat));
            check("sclk_rises", 32'(rises), 32'(WIDTH));
            check("busy_in_done", 32'(busy), 32'(1));
            check("cs_high_at_done", 32'(cs), 32'(1));
          end
        end
      end
      prev_cs = cs; prev_sclk = sclk; prev_done = done;
    end
  end

  // Counts sclk rises and high cycles of the CLK_DIV=1 instance per transfer.
  int rises1 = 0;
  int hi1 = 0;
  initial begin
    logic pcs1, psclk1;
    pcs1 = 1'b1; psclk1 = 1'b0;
    forever begin
      @(negedge clk);
      if (pcs1 === 1'b1 && cs1 === 1'b0) begin
        rises1 = 0;
        hi1 = 0;
      end
      if (cs1 === 1'b0 && psclk1 === 1'b0 && sclk1 === 1'b1) rises1++;
      if (cs1 === 1'b0 && sclk1 === 1'b1) hi1++;
      pcs1 = cs1; psclk1 = sclk1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, acc;
    bit ok;
    rst = 1'b1; start = 1'b0; tx_data = '0;
    sel_periph = 1'b0; periph_load = 1'b0;
    start1 = 1'b0; tx1 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cs", 32'(cs), 32'(1));
    check("rst_sclk", 32'(sclk), 32'(0));
    check("rst_mosi", 32'(mosi), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_rx", 32'(rx_data), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Loopback A5
    push_txn(8'hA5, 8'hA5, WIDTH);
    pulse_start(8'hA5);
    check("busy_after_accept", 32'(busy), 32'(1));
    check("cs_after_accept", 32'(cs), 32'(0));
    check("mosi_bit0_at_cs", 32'(mosi), 32'(1));
    wait_done(LAT4 + 10);
    @(negedge clk);
    check("busy_drop", 32'(busy), 32'(0));
    check("rx_hold", 32'(rx_data), 32'(8'hA5));

    // Peripheral preloaded with 3C, master sends 96; txData changes after accept
    periph_load = 1'b1;
    @(negedge clk);
    periph_load = 1'b0;
    sel_periph = 1'b1;
    push_txn(8'h96, 8'h3C, WIDTH);
    pulse_start(8'h96);
    tx_data = 8'h00;
    check("rx_hold_during_next", 32'(rx_data), 32'(8'hA5));
    wait_done(LAT4 + 10);
    check("periph_rx", 32'(periph_q), 32'(8'h96));
    @(negedge clk);
    sel_periph = 1'b0;

    // start re-pulsed at cycles 10 and 40 with FF is ignored
    push_txn(8'hA5, 8'hA5, WIDTH);
    pulse_start(8'hA5);
    repeat (9) @(negedge clk);
    tx_data = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(LAT4);
    repeat (80) @(negedge clk);
    check("single_done_pending", 32'(exp_q.size()), 32'(0));
    check("idle_cs", 32'(cs), 32'(1));
    check("idle_busy", 32'(busy), 32'(0));

    // start held high: two back-to-back transfers
    push_txn(8'h69, 8'h69, WIDTH);
    push_txn(8'h81, 8'h81, WIDTH);
    tx_data = 8'h69; start = 1'b1;
    @(negedge clk);
    tx_data = 8'h81;
    wait_done(LAT4 + 10);
    d1 = cyc;
    check("b2b_cs_high", 32'(cs), 32'(1));
    @(negedge clk);
    check("b2b_cs_low_again", 32'(cs), 32'(0));
    check("b2b_busy", 32'(busy), 32'(1));
    start = 1'b0;
    wait_done(LAT4 + 10);
    check("b2b_done_gap", 32'(cyc - d1), 32'(LAT4 + 1));
    @(negedge clk);

    // Reset at cycle 30 of a transfer: only 4 bits go out
    push_txn(8'hC3, 8'h00, 4);
    pulse_start(8'hC3);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cs", 32'(cs), 32'(1));
    check("mid_rst_sclk", 32'(sclk), 32'(0));
    check("mid_rst_mosi", 32'(mosi), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_rx", 32'(rx_data), 32'(0));
    check("mid_rst_done", 32'(done), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    push_txn(8'h3C, 8'h3C, WIDTH);
    pulse_start(8'h3C);
    wait_done(LAT4 + 10);
    @(negedge clk);

    // CLK_DIV=1 instance, loopback 5A
    tx1 = 8'h5A; start1 = 1'b1;
    @(negedge clk);
    acc = cyc;
    start1 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done1 === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      fail_now("div1_done_timeout");
    end else begin
      check("div1_rx", 32'(rx1), 32'(8'h5A));
      check("div1_latency", 32'(cyc - acc), 32'(LAT1));
      check("div1_rises", 32'(rises1), 32'(WIDTH));
      check("div1_high_cycles", 32'(hi1), 32'(WIDTH));
      check("div1_busy_in_done", 32'(busy1), 32'(1));
    end

    repeat (5) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'(0));
    check("exp_bits_empty", 32'(exp_bits.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
